ts_word_unpack: RTL and testbench
=================================

# ts_word_unpack

Downstream stage of the UDP TS splitter. It consumes the 33-bit word stream (header word with bit 32 set, then IP word, port word, then 47 TS payload words per packet) and buffers complete 188-byte TS packets in a two-slot packet buffer. It replays each buffered packet as a continuous byte stream tagged with its SFP number, IP and port, and feeds the per-channel TS processing that follows.

## Interface
Parameters:
- TS_WORDS, 47: payload words per TS packet (188 bytes).
- SYNC_BYTE, 8'h47: required first byte of every TS packet.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ts_din  in  33  upstream word; bit 32 = header flag; header word carries SFP number in [7:0].
- ts_din_en  in  1  word valid; no backpressure exists.
- ts_dout  out  8  TS byte.
- ts_dout_en  out  1  byte valid.
- ts_sop  out  1  high with byte 0 of a packet.
- ts_eop  out  1  high with byte 187 of a packet.
- ts_sfp  out  8  SFP number of the current packet, stable from sop to eop.
- ts_ip  out  32  destination IP of the current packet, stable from sop to eop.
- ts_port  out  16  destination port of the current packet, stable from sop to eop.
- drop_cnt  out  16  count of dropped packets, saturating at 16'hFFFF.
- sync_err_cnt  out  16  count of sync failures, saturating at 16'hFFFF.

## Operation
- Buffer: 2 slots × TS_WORDS × 32 bits, each with a valid flag and a metadata copy (sfp, ip, port). Pointers wr_slot and rd_slot toggle.
- Write FSM (advances only on ts_din_en):
  - W_HDR: wait for bit 32 = 1; latch sfp from [7:0]; go to W_IP.
  - W_IP: latch ip = [31:0]; go to W_PORT.
  - W_PORT: latch port = [15:0]; go to W_TS.
  - W_TS: on the first word:
    - if slot[wr_slot] is valid, go to W_SKIP and increment drop_cnt;
    - else if [31:24] != SYNC_BYTE, go to W_SKIP and increment sync_err_cnt;
    - else store the word.
    - Subsequent words are stored at address word_cnt. On the TS_WORDS-th word, set slot valid, store metadata, toggle wr_slot, and stay in W_TS (word_cnt = 0) for the next packet under the same header.
  - W_SKIP: discard words until word_cnt reaches TS_WORDS, then return to W_TS.
  - A header word in any state aborts the partial packet: slot valid stays clear and wr_slot is unchanged. drop_cnt increments only if W_TS had ≥1 stored word. The new sfp is latched and the FSM goes to W_IP.
- Read FSM:
  - R_IDLE: if slot[rd_slot] is valid, go to R_LOAD.
  - R_LOAD: issue the word 0 read; go to R_BYTE.
  - R_BYTE: emit 4 bytes per word, MSB first, with prefetch so ts_dout_en stays high for 188 consecutive cycles. After byte 187: clear the valid flag, toggle rd_slot, go to R_IDLE.
- ts_ip, ts_port and ts_sfp are loaded from slot metadata in R_LOAD.

## Timing
- Reset, asynchronous:
  - All outputs are 0, including both counters.
  - Both valid flags are clear and both pointers are 0.
  - Write FSM is in W_HDR; read FSM is in R_IDLE.
- Latency: if the 47th word is sampled at edge N and the read FSM is idle, ts_sop/ts_dout_en are high in the cycle following edge N+3.
- A packet produces exactly 188 contiguous bytes. At least one idle cycle separates eop from the next sop.
- The write and read sides never touch the same slot. If a valid set and a valid clear occur in the same cycle, both take effect.
- Counter saturation: at 16'hFFFF, a further event leaves the value at 16'hFFFF.
- Input gaps (ts_din_en low) anywhere in a packet are tolerated with no effect.
- Reset asserted mid-packet discards everything immediately. Output goes to 0 on the asynchronous edge; no partial tail is emitted after release.

## Configuration
- TS_SYNC_CHECK_EN:
  - Defined: the first-word SYNC_BYTE check is active as described.
  - Undefined: the check logic is removed, packets are accepted regardless of byte 0, and sync_err_cnt is tied to 0.

## Test plan
- Header (sfp=1), ip=32'hC0A80001, port=16'h04D2, then 47 words with word 0 = 32'h47001011 -> 188 bytes. Byte 0 = 8'h47 with sop at N+3; eop on byte 187; ts_ip/ts_port/ts_sfp match.
- Seven back-to-back packets with a 140-cycle gap between each -> seven packets out in order, drop_cnt = 0.
- Three packets with no inter-packet gap while output is stalled by buffer occupancy -> third packet dropped, drop_cnt = 1, first two emitted intact.
- Word 0 = 32'h12345678 -> no output, sync_err_cnt = 1. Rerun with TS_SYNC_CHECK_EN undefined -> packet emitted, byte 0 = 8'h12.
- Header word after 20 payload words -> partial packet discarded, drop_cnt = 1, following full packet emitted with the new metadata.
- Assert rst during byte 100 of output -> ts_dout_en = 0 immediately, counters = 0; a fresh packet after release emits normally.

Source files
------------

// File: rtl/ts_word_unpack.sv
// ts_word_unpack: turns the 33-bit header/IP/port/payload word stream into a
// contiguous 188-byte TS packet stream, buffered through a two-slot packet
// store. Build option TS_SYNC_CHECK_EN enables the first-byte sync check and
// the sync error counter; without it every packet is accepted and
// sync_err_cnt reads as zero.
module ts_word_unpack #(
  parameter int          TS_WORDS  = 47,
  parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [32:0] ts_din,
  input  logic        ts_din_en,
  output logic [7:0]  ts_dout,
  output logic        ts_dout_en,
  output logic        ts_sop,
  output logic        ts_eop,
  output logic [7:0]  ts_sfp,
  output logic [31:0] ts_ip,
  output logic [15:0] ts_port,
  output logic [15:0] drop_cnt,
  output logic [15:0] sync_err_cnt
);

  localparam int WC_W  = $clog2(TS_WORDS + 1);
  localparam int DEPTH = 2 * TS_WORDS;
  localparam int AW    = $clog2(DEPTH);
  localparam int BC_W  = $clog2(4 * TS_WORDS);

  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(TS_WORDS - 1);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(4 * TS_WORDS - 1);

  typedef enum logic [2:0] {W_HDR, W_IP, W_PORT, W_TS, W_SKIP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_BYTE} rd_state_e;

  // Slot 0 occupies words [0, TS_WORDS), slot 1 the next TS_WORDS words.
  function automatic logic [AW-1:0] slot_addr(input logic slot,
                                              input logic [WC_W-1:0] word);
    return slot ? (AW'(TS_WORDS) + AW'(word)) : AW'(word);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_state_e         wr_state_q, wr_state_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              wr_slot_q,  wr_slot_d;
  logic [7:0]        cur_sfp_q,  cur_sfp_d;
  logic [31:0]       cur_ip_q,   cur_ip_d;
  logic [15:0]       cur_port_q, cur_port_d;

  logic [1:0]        valid_q,    valid_d;
  logic [1:0][7:0]   meta_sfp_q,  meta_sfp_d;
  logic [1:0][31:0]  meta_ip_q,   meta_ip_d;
  logic [1:0][15:0]  meta_port_q, meta_port_d;

  rd_state_e         rd_state_q, rd_state_d;
  logic              rd_slot_q,  rd_slot_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [31:0]       rd_word_q,  rd_word_d;

  logic [7:0]        dout_q,  dout_d;
  logic              dout_en_q, dout_en_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [7:0]        sfp_q,  sfp_d;
  logic [31:0]       ip_q,   ip_d;
  logic [15:0]       port_q, port_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     mem_raddr;
  logic [31:0]       mem_rdata;

  logic              set_valid;
  logic              clr_valid;
  logic              drop_inc;

`ifdef TS_SYNC_CHECK_EN
  logic [15:0]       sync_err_cnt_q, sync_err_cnt_d;
  logic              sync_inc;
`endif

  // ---------------------------------------------------------------------------
  // Write side: parse header/IP/port, store payload words into wr_slot
  // ---------------------------------------------------------------------------
  // Write FSM next-state, metadata capture and buffer write strobes.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    wr_state_d = wr_state_q;
    word_cnt_d = word_cnt_q;
    wr_slot_d  = wr_slot_q;
    cur_sfp_d  = cur_sfp_q;
    cur_ip_d   = cur_ip_q;
    cur_port_d = cur_port_q;
    mem_we     = 1'b0;
    mem_waddr  = slot_addr(wr_slot_q, word_cnt_q);
    set_valid  = 1'b0;
    drop_inc   = 1'b0;
`ifdef TS_SYNC_CHECK_EN
    sync_inc   = 1'b0;
`endif
    if (ts_din_en) begin
      if (ts_din[32]) begin
        // A header always restarts parsing; a partially stored packet is lost.
        if (wr_state_q == W_TS && word_cnt_q != '0) drop_inc = 1'b1;
        cur_sfp_d  = ts_din[7:0];
        word_cnt_d = '0;
        wr_state_d = W_IP;
      end else begin
        unique case (wr_state_q)
          W_HDR: ;
          W_IP: begin
            cur_ip_d   = ts_din[31:0];
            wr_state_d = W_PORT;
          end
          W_PORT: begin
            cur_port_d = ts_din[15:0];
            word_cnt_d = '0;
            wr_state_d = W_TS;
          end
          W_TS: begin
            if (word_cnt_q == '0 && valid_q[wr_slot_q]) begin
              drop_inc   = 1'b1;
              word_cnt_d = WC_W'(1);
              wr_state_d = W_SKIP;
            end
`ifdef TS_SYNC_CHECK_EN
            else if (word_cnt_q == '0 && ts_din[31:24] != SYNC_BYTE) begin
              sync_inc   = 1'b1;
              word_cnt_d = WC_W'(1);
              wr_state_d = W_SKIP;
            end
`endif
            else begin
              mem_we = 1'b1;
              if (word_cnt_q == LAST_WORD) begin
                set_valid  = 1'b1;
                wr_slot_d  = ~wr_slot_q;
                word_cnt_d = '0;
              end else begin
                word_cnt_d = word_cnt_q + WC_W'(1);
              end
            end
          end
          W_SKIP: begin
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              wr_state_d = W_TS;
            end else begin
              word_cnt_d = word_cnt_q + WC_W'(1);
            end
          end
          default: wr_state_d = W_HDR;
        endcase
      end
    end
  end

  // Packet store write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the valid flags decide what is
    // readable, so stale contents are never emitted.
    if (mem_we) mem[mem_waddr] <= ts_din[31:0];
  end

  // Slot valid flags and per-slot metadata; set and clear may coincide on
  // different slots and both take effect.
  always_comb begin
    valid_d     = valid_q;
    meta_sfp_d  = meta_sfp_q;
    meta_ip_d   = meta_ip_q;
    meta_port_d = meta_port_q;
    if (set_valid) begin
      valid_d[wr_slot_q]     = 1'b1;
      meta_sfp_d[wr_slot_q]  = cur_sfp_q;
      meta_ip_d[wr_slot_q]   = cur_ip_q;
      meta_port_d[wr_slot_q] = cur_port_q;
    end
    if (clr_valid) valid_d[rd_slot_q] = 1'b0;
  end

  // Saturating event counters.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`ifdef TS_SYNC_CHECK_EN
    sync_err_cnt_d = sync_err_cnt_q;
    if (sync_inc && sync_err_cnt_q != 16'hFFFF)
      sync_err_cnt_d = sync_err_cnt_q + 16'd1;
`endif
  end

  // ---------------------------------------------------------------------------
  // Read side: replay a valid slot as 188 back-to-back bytes
  // ---------------------------------------------------------------------------
  // Read address: word 0 on load, next word while the last byte of the
  // current one is emitted, so the byte stream never stalls.
  always_comb begin
    mem_raddr = slot_addr(rd_slot_q, '0);
    if (rd_state_q == R_BYTE)
      mem_raddr = slot_addr(rd_slot_q, WC_W'(byte_cnt_q >> 2) + WC_W'(1));
  end

  assign mem_rdata = mem[mem_raddr];

  // Read FSM next-state and registered byte outputs.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_slot_d  = rd_slot_q;
    byte_cnt_d = byte_cnt_q;
    rd_word_d  = rd_word_q;
    clr_valid  = 1'b0;
    dout_d     = '0;
    dout_en_d  = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    sfp_d      = sfp_q;
    ip_d       = ip_q;
    port_d     = port_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (valid_q[rd_slot_q]) rd_state_d = R_LOAD;
      end
      R_LOAD: begin
        rd_word_d  = mem_rdata;
        sfp_d      = meta_sfp_q[rd_slot_q];
        ip_d       = meta_ip_q[rd_slot_q];
        port_d     = meta_port_q[rd_slot_q];
        byte_cnt_d = '0;
        rd_state_d = R_BYTE;
      end
      R_BYTE: begin
        dout_en_d = 1'b1;
        sop_d     = (byte_cnt_q == '0);
        unique case (byte_cnt_q[1:0])
          2'd0: dout_d = rd_word_q[31:24];
          2'd1: dout_d = rd_word_q[23:16];
          2'd2: dout_d = rd_word_q[15:8];
          default: dout_d = rd_word_q[7:0];
        endcase
        if (byte_cnt_q == LAST_BYTE) begin
          eop_d      = 1'b1;
          clr_valid  = 1'b1;
          rd_slot_d  = ~rd_slot_q;
          rd_state_d = R_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          if (byte_cnt_q[1:0] == 2'd3) rd_word_d = mem_rdata;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // All control and output state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_state_q  <= W_HDR;
      word_cnt_q  <= '0;
      wr_slot_q   <= 1'b0;
      cur_sfp_q   <= '0;
      cur_ip_q    <= '0;
      cur_port_q  <= '0;
      valid_q     <= '0;
      meta_sfp_q  <= '0;
      meta_ip_q   <= '0;
      meta_port_q <= '0;
      rd_state_q  <= R_IDLE;
      rd_slot_q   <= 1'b0;
      byte_cnt_q  <= '0;
      rd_word_q   <= '0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      sfp_q       <= '0;
      ip_q        <= '0;
      port_q      <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      word_cnt_q  <= word_cnt_d;
      wr_slot_q   <= wr_slot_d;
      cur_sfp_q   <= cur_sfp_d;
      cur_ip_q    <= cur_ip_d;
      cur_port_q  <= cur_port_d;
      valid_q     <= valid_d;
      meta_sfp_q  <= meta_sfp_d;
      meta_ip_q   <= meta_ip_d;
      meta_port_q <= meta_port_d;
      rd_state_q  <= rd_state_d;
      rd_slot_q   <= rd_slot_d;
      byte_cnt_q  <= byte_cnt_d;
      rd_word_q   <= rd_word_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      sfp_q       <= sfp_d;
      ip_q        <= ip_d;
      port_q      <= port_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef TS_SYNC_CHECK_EN
  // Sync error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_err_cnt_q <= '0;
    else     sync_err_cnt_q <= sync_err_cnt_d;
  end
  assign sync_err_cnt = sync_err_cnt_q;
`else
  assign sync_err_cnt = 16'h0000;
`endif

  assign ts_dout    = dout_q;
  assign ts_dout_en = dout_en_q;
  assign ts_sop     = sop_q;
  assign ts_eop     = eop_q;
  assign ts_sfp     = sfp_q;
  assign ts_ip      = ip_q;
  assign ts_port    = port_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ts_word_unpack.sv
// Directed testbench for ts_word_unpack: drives header/IP/port/payload word
// sequences, captures the emitted byte stream per packet and compares it with
// hand-built expected packets and counter values.
module tb_ts_word_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] ts_din = '0;
  logic        ts_din_en = 1'b0;
  logic [7:0]  ts_dout;
  logic        ts_dout_en;
  logic        ts_sop;
  logic        ts_eop;
  logic [7:0]  ts_sfp;
  logic [31:0] ts_ip;
  logic [15:0] ts_port;
  logic [15:0] drop_cnt;
  logic [15:0] sync_err_cnt;

  ts_word_unpack dut (
    .clk          (clk),
    .rst          (rst),
    .ts_din       (ts_din),
    .ts_din_en    (ts_din_en),
    .ts_dout      (ts_dout),
    .ts_dout_en   (ts_dout_en),
    .ts_sop       (ts_sop),
    .ts_eop       (ts_eop),
    .ts_sfp       (ts_sfp),
    .ts_ip        (ts_ip),
    .ts_port      (ts_port),
    .drop_cnt     (drop_cnt),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor: one record per packet bounded by sop..eop
  // ---------------------------------------------------------------------------
  localparam int MAXP = 32;
  logic [7:0]  rx_bytes [MAXP][188];
  int          rx_len   [MAXP];
  int          rx_sop_cyc [MAXP];
  int          rx_meta_err [MAXP];
  logic [7:0]  rx_sfp  [MAXP];
  logic [31:0] rx_ip   [MAXP];
  logic [15:0] rx_port [MAXP];
  int rx_cnt  = 0;
  int pos     = 0;
  int in_pkt  = 0;
  int gap_err = 0;
  int stray   = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 0;
      pos    = 0;
    end else if (ts_dout_en) begin
      if (ts_sop) begin
        if (in_pkt != 0) stray++;
        in_pkt = 1;
        pos = 0;
        if (rx_cnt < MAXP) begin
          rx_sfp[rx_cnt]      = ts_sfp;
          rx_ip[rx_cnt]       = ts_ip;
          rx_port[rx_cnt]     = ts_port;
          rx_sop_cyc[rx_cnt]  = cyc;
          rx_meta_err[rx_cnt] = 0;
        end
      end
      if (in_pkt != 0 && rx_cnt < MAXP) begin
        if (pos < 188) rx_bytes[rx_cnt][pos] = ts_dout;
        if (ts_sfp != rx_sfp[rx_cnt] || ts_ip != rx_ip[rx_cnt] ||
            ts_port != rx_port[rx_cnt]) rx_meta_err[rx_cnt]++;
        pos++;
        if (ts_eop) begin
          rx_len[rx_cnt] = pos;
          in_pkt = 0;
          rx_cnt++;
        end
      end else begin
        stray++;
      end
    end else if (in_pkt != 0) begin
      gap_err++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int last_cyc = 0;

  function automatic logic [31:0] pkt_word(input int seed, input int w,
                                           input logic [31:0] w0);
    logic [7:0] s;
    logic [7:0] wb;
    s  = seed[7:0];
    wb = w[7:0];
    if (w == 0) return w0;
    return {s, wb, 8'hA5 ^ s, wb + 8'h03};
  endfunction

  function automatic logic [7:0] exp_byte(input int seed, input int b,
                                          input logic [31:0] w0);
    logic [31:0] wd;
    wd = pkt_word(seed, b / 4, w0);
    return wd[8 * (3 - (b % 4)) +: 8];
  endfunction

  task automatic send_word(input logic [32:0] w);
    @(negedge clk);
    ts_din    = w;
    ts_din_en = 1'b1;
    last_cyc  = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ts_din    = '0;
      ts_din_en = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [7:0] sfp, input logic [31:0] ip,
                          input logic [15:0] port);
    send_word({1'b1, 24'h0, sfp});
    send_word({1'b0, ip});
    send_word({1'b0, 16'h0, port});
  endtask

  task automatic send_payload(input int seed, input logic [31:0] w0,
                              input int nwords, input int gappy);
    for (int w = 0; w < nwords; w++) begin
      if (gappy != 0 && (w % 5) == 2) idle(1 + (w % 3));
      send_word({1'b0, pkt_word(seed, w, w0)});
    end
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_cnt, n);
  endtask

  task automatic check_pkt(input int idx, input int seed, input logic [31:0] w0,
                           input logic [7:0] sfp, input logic [31:0] ip,
                           input logic [15:0] port);
    if (idx >= rx_cnt || idx >= MAXP) begin
      check("pkt_present", idx, rx_cnt);
    end else begin
      check("pkt_len", rx_len[idx], 188);
      check("pkt_sfp", rx_sfp[idx], sfp);
      check("pkt_ip", rx_ip[idx], ip);
      check("pkt_port", rx_port[idx], port);
      check("pkt_meta_stable", rx_meta_err[idx], 0);
      for (int b = 0; b < 188; b++)
        check($sformatf("pkt%0d_byte%0d", idx, b), rx_bytes[idx][b],
              exp_byte(seed, b, w0));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int exp_drop = 0;
  int base = 0;
  int k;

  initial begin
    // Reset state.
    #12;
    check("rst_dout_en", ts_dout_en, 0);
    check("rst_dout", ts_dout, 0);
    check("rst_sop_eop", {ts_sop, ts_eop}, 0);
    check("rst_meta", {ts_sfp, ts_ip[23:0]} ^ {16'h0, ts_port}, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_sync", sync_err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Single packet: metadata, byte order, sop latency.
    send_hdr(8'd1, 32'hC0A80001, 16'h04D2);
    send_payload(1, 32'h47001011, 47, 0);
    idle(1);
    wait_rx("t1_count", 1, 400);
    check("t1_latency", rx_sop_cyc[0], last_cyc + 4);
    check("t1_byte0", rx_bytes[0][0], 8'h47);
    check("t1_byte3", rx_bytes[0][3], 8'h11);
    check_pkt(0, 1, 32'h47001011, 8'd1, 32'hC0A80001, 16'h04D2);
    idle(10);

    // Seven packets, each with its own header, 140 idle cycles apart.
    base = rx_cnt;
    for (int p = 0; p < 7; p++) begin
      send_hdr(8'(10 + p), 32'h0A000000 + p, 16'(1000 + p));
      send_payload(20 + p, {8'h47, 8'(p), 16'h2000}, 47, 0);
      if (p == 0) k = last_cyc;
      idle(140);
    end
    wait_rx("t2_count", base + 7, 800);
    check("t2_latency", rx_sop_cyc[base], k + 4);
    for (int p = 0; p < 7; p++)
      check_pkt(base + p, 20 + p, {8'h47, 8'(p), 16'h2000}, 8'(10 + p),
                32'h0A000000 + p, 16'(1000 + p));
    check("t2_drop", drop_cnt, 0);
    idle(20);

    // Three packets back to back under one header: third finds its slot busy.
    base = rx_cnt;
    send_hdr(8'd3, 32'hAC100005, 16'h1F90);
    for (int p = 0; p < 3; p++)
      send_payload(40 + p, {8'h47, 8'(40 + p), 16'h3000}, 47, 0);
    idle(1);
    exp_drop++;
    wait_rx("t3_count", base + 2, 800);
    idle(300);
    check("t3_count_final", rx_cnt, base + 2);
    check("t3_drop", drop_cnt, exp_drop);
    check_pkt(base, 40, {8'h47, 8'd40, 16'h3000}, 8'd3, 32'hAC100005, 16'h1F90);
    check_pkt(base + 1, 41, {8'h47, 8'd41, 16'h3000}, 8'd3, 32'hAC100005,
              16'h1F90);

    // Bad sync byte.
    base = rx_cnt;
    send_hdr(8'd4, 32'h01020304, 16'h0050);
    send_payload(50, 32'h12345678, 47, 0);
    idle(1);
`ifdef TS_SYNC_CHECK_EN
    idle(300);
    check("t4_no_output", rx_cnt, base);
    check("t4_sync_err", sync_err_cnt, 1);
`else
    wait_rx("t4_count", base + 1, 400);
    check("t4_byte0", rx_bytes[base][0], 8'h12);
    check_pkt(base, 50, 32'h12345678, 8'd4, 32'h01020304, 16'h0050);
    check("t4_sync_err", sync_err_cnt, 0);
    idle(10);
`endif

    // Header after 20 payload words aborts the partial packet.
    base = rx_cnt;
    send_hdr(8'd5, 32'h05050505, 16'h0505);
    send_payload(60, 32'h47050505, 20, 0);
    send_hdr(8'd9, 32'h09090909, 16'h0909);
    send_payload(61, 32'h47090909, 47, 0);
    idle(1);
    exp_drop++;
    wait_rx("t5_count", base + 1, 400);
    check("t5_drop", drop_cnt, exp_drop);
    check_pkt(base, 61, 32'h47090909, 8'd9, 32'h09090909, 16'h0909);
    idle(20);
    check("t5_single", rx_cnt, base + 1);

    // Reset during byte 100 of the output.
    base = rx_cnt;
    send_hdr(8'd6, 32'h06060606, 16'h0606);
    send_payload(70, 32'h47060606, 47, 0);
    idle(1);
    k = 0;
    while (!(in_pkt != 0 && pos >= 100) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("t6_reached_b100", pos, 100);
    #2 rst = 1'b1;
    #1;
    check("t6_dout_en", ts_dout_en, 0);
    check("t6_dout", {ts_dout, 6'h0, ts_sop, ts_eop}, 0);
    check("t6_drop_clr", drop_cnt, 0);
    check("t6_sync_clr", sync_err_cnt, 0);
    idle(3);
    rst = 1'b0;
    idle(300);
    check("t6_no_tail", rx_cnt, base);

    // Fresh packet after reset with input gaps sprinkled through it.
    send_hdr(8'd7, 32'h07070707, 16'h0707);
    send_payload(80, 32'h47070707, 47, 1);
    idle(1);
    wait_rx("t7_count", base + 1, 400);
    check_pkt(base, 80, 32'h47070707, 8'd7, 32'h07070707, 16'h0707);
    check("t7_drop", drop_cnt, 0);
    idle(10);

    check("mon_gap_err", gap_err, 0);
    check("mon_stray", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
